pacing_scheduler: RTL and testbench

Downstream consumer of the clock-divider stage in the generated RTLola monitor. Detects rising edges on the two divided pacing clocks and accepts asynchronous input events. Merges everything that happens in one cycle into a single timestamped evaluation task. Buffers tasks in a small FIFO and hands them to the stream-evaluation stage over a valid/ready handshake.

---
 rtl/pacing_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 55 +++++
 rtl/pacing_scheduler.sv | 81 ++++++++
 tb/tb_pacing_scheduler.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pacing_pkg.sv
// Shared definitions for the pacing scheduler: task-kind bit positions,
// default widths and the task record layout.
package pacing_pkg;

  localparam int KIND_W     = 3;
  localparam int KIND_EVENT = 0;
  localparam int KIND_PACE0 = 1;
  localparam int KIND_PACE1 = 2;

  localparam int DATA_W_DEF = 32;
  localparam int TS_W_DEF   = 32;

  typedef struct packed {
    logic [KIND_W-1:0]     kind;
    logic [DATA_W_DEF-1:0] data;
    logic [TS_W_DEF-1:0]   ts;
  } task_t;

  function automatic logic [KIND_W-1:0] make_kind(input logic ev,
                                                  input logic pace_0,
                                                  input logic pace_1);
    logic [KIND_W-1:0] kind;
    kind             = '0;
    kind[KIND_EVENT] = ev;
    kind[KIND_PACE0] = pace_0;
    kind[KIND_PACE1] = pace_1;
    return kind;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Count-based synchronous FIFO; a push into a full FIFO is accepted when a
// pop happens in the same cycle. Head reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

  // NOTE: storage has no reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pacing_scheduler.sv
// Merges pacing-clock edges and input events of one cycle into a single
// timestamped task and queues it for the stream-evaluation stage.
module pacing_scheduler
  import pacing_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TS_W   = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              div_0,
  input  logic              div_1,
  input  logic              ev_valid,
  input  logic [DATA_W-1:0] ev_data,
  output logic              task_valid,
  input  logic              task_ready,
  output logic [KIND_W-1:0] task_kind,
  output logic [DATA_W-1:0] task_data,
  output logic [TS_W-1:0]   task_ts,
  output logic              overflow
);

  localparam int WORD_W = KIND_W + DATA_W + TS_W;

  logic [TS_W-1:0]   r_ts;
  logic              r_prev_0;
  logic              r_prev_1;
  logic              r_overflow;
  logic              w_pace_0;
  logic              w_pace_1;
  logic [KIND_W-1:0] w_kind;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [WORD_W-1:0] w_wdata;
  logic [WORD_W-1:0] w_rdata;

  assign w_pace_0 = div_0 & ~r_prev_0;
  assign w_pace_1 = div_1 & ~r_prev_1;
  assign w_kind   = make_kind(ev_valid, w_pace_0, w_pace_1);
  assign w_push   = en & (|w_kind);
  assign w_pop    = en & ~w_empty & task_ready;
  assign w_wdata  = {w_kind, (ev_valid ? ev_data : {DATA_W{1'b0}}), r_ts};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ts       <= '0;
      r_prev_0   <= 1'b0;
      r_prev_1   <= 1'b0;
      r_overflow <= 1'b0;
    end else if (en) begin
      r_ts     <= r_ts + TS_W'(1);
      r_prev_0 <= div_0;
      r_prev_1 <= div_1;
      // A full queue only loses the task when the head is not leaving this cycle.
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign task_valid                       = ~w_empty;
  assign {task_kind, task_data, task_ts}  = w_rdata;
  assign overflow                         = r_overflow;

endmodule

// File: tb/tb_pacing_scheduler.sv
// Directed bench: default-width instance for edge/event/FIFO behaviour and a
// 4-bit timestamp instance for wrap-around and enable freezing.
module tb_pacing_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default widths.
  logic        rst, en, div_0, div_1, ev_valid, task_ready;
  logic [31:0] ev_data;
  logic        task_valid, overflow;
  logic [2:0]  task_kind;
  logic [31:0] task_data, task_ts;

  // Instance B: 4-bit timestamp.
  logic        b_rst, b_en, b_div_0, b_div_1, b_ev_valid, b_ready;
  logic [31:0] b_ev_data;
  logic        b_valid, b_overflow;
  logic [2:0]  b_kind;
  logic [31:0] b_data;
  logic [3:0]  b_ts;

  int n_checks = 0;
  int n_pass   = 0;

  pacing_scheduler dut_a (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .div_0      (div_0),
    .div_1      (div_1),
    .ev_valid   (ev_valid),
    .ev_data    (ev_data),
    .task_valid (task_valid),
    .task_ready (task_ready),
    .task_kind  (task_kind),
    .task_data  (task_data),
    .task_ts    (task_ts),
    .overflow   (overflow)
  );

  pacing_scheduler #(.DATA_W(32), .TS_W(4), .DEPTH(4)) dut_b (
    .clk        (clk),
    .rst        (b_rst),
    .en         (b_en),
    .div_0      (b_div_0),
    .div_1      (b_div_1),
    .ev_valid   (b_ev_valid),
    .ev_data    (b_ev_data),
    .task_valid (b_valid),
    .task_ready (b_ready),
    .task_kind  (b_kind),
    .task_data  (b_data),
    .task_ts    (b_ts),
    .overflow   (b_overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; div_0 = 1'b0; div_1 = 1'b0;
    ev_valid = 1'b0; ev_data = '0; task_ready = 1'b1;
    b_rst = 1'b0; b_en = 1'b1; b_div_0 = 1'b0; b_div_1 = 1'b0;
    b_ev_valid = 1'b0; b_ev_data = '0; b_ready = 1'b0;

    // Reset for three cycles.
    step(3);
    check("rst_valid", task_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_ts", task_ts, 0);
    check("rst_kind", task_kind, 0);
    rst = 1'b1;

    // Enabled cycles 0..9 idle; div_0 rises in cycle 10.
    step(10);
    check("idle_valid", task_valid, 0);
    div_0 = 1'b1;
    step();
    check("pace0_valid", task_valid, 1);
    check("pace0_kind", task_kind, 3'b010);
    check("pace0_ts", task_ts, 10);
    check("pace0_data", task_data, 0);
    step();  // cycle 11: popped, div_0 still high
    check("pace0_popped", task_valid, 0);
    step(8); // cycles 12..19
    check("pace0_no_retrigger", task_valid, 0);

    // Cycle 20: event and div_1 edge coincide.
    ev_valid = 1'b1; ev_data = 32'hDEAD_BEEF; div_1 = 1'b1;
    step();
    ev_valid = 1'b0;
    check("merge_valid", task_valid, 1);
    check("merge_kind", task_kind, 3'b101);
    check("merge_data", task_data, 32'hDEAD_BEEF);
    check("merge_ts", task_ts, 20);
    step();  // cycle 21: pop, no new task
    check("merge_single", task_valid, 0);

    // Cycles 22..26: five events with the evaluator stalled.
    task_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      ev_valid = 1'b1; ev_data = 32'(i);
      step();
      if (i == 4) check("ovf_before_drop", overflow, 0);
    end
    ev_valid = 1'b0;
    check("ovf_set", overflow, 1);
    check("ovf_head_data", task_data, 1);
    check("ovf_head_ts", task_ts, 22);
    task_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      step();
      check("drain_data", task_data, 64'(i));
    end
    step();
    check("drain_empty", task_valid, 0);
    check("ovf_sticky", overflow, 1);

    // Reset mid-run clears overflow; then fill and push while popping.
    rst = 1'b0;
    step();
    check("rst2_overflow", overflow, 0);
    check("rst2_valid", task_valid, 0);
    rst = 1'b1;
    task_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ev_valid = 1'b1; ev_data = 32'h10 + 32'(i);
      step();
    end
    check("full_head", task_data, 32'h10);
    task_ready = 1'b1; ev_data = 32'h14;
    step();  // cycle 4: pop 0x10, push 0x14
    ev_valid = 1'b0;
    check("fullpp_overflow", overflow, 0);
    for (int i = 1; i <= 4; i++) begin
      check("fullpp_data", task_data, 64'(32'h10 + i));
      if (i == 4) check("fullpp_ts", task_ts, 4);
      step();
    end
    check("fullpp_count4", task_valid, 0);

    // Instance B: 4-bit timestamp wraps; event in cycle 17 carries ts 1.
    b_rst = 1'b1;
    step(17);
    b_ev_valid = 1'b1; b_ev_data = 32'hAB;
    step();  // cycle 17
    b_ev_valid = 1'b0;
    check("wrap_ts", b_ts, 1);
    check("wrap_kind", b_kind, 3'b001);
    step(2); // cycles 18, 19

    // Freeze: inputs and ready ignored for 5 cycles.
    b_en = 1'b0; b_ready = 1'b1; b_ev_valid = 1'b1; b_ev_data = 32'hCD; b_div_0 = 1'b1;
    step(5);
    check("frz_valid", b_valid, 1);
    check("frz_data", b_data, 32'hAB);
    check("frz_ts", b_ts, 1);
    check("frz_kind", b_kind, 3'b001);

    // Cycle 20 after resume: pop old head, push new event with ts 20 mod 16.
    b_en = 1'b1; b_div_0 = 1'b0; b_ev_data = 32'hEF;
    step();
    b_ev_valid = 1'b0;
    check("resume_data", b_data, 32'hEF);
    check("resume_ts", b_ts, 4);
    check("resume_kind", b_kind, 3'b001);
    step();
    check("resume_drained", b_valid, 0);
    check("b_overflow", b_overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
